data_sram_bridge: RTL and testbench

- Memory-side responder for the pipeline's data SRAM port.
- Accepts the EX-stage request (en, wen, addr, wdata) and serves it over a variable-latency valid/ready memory bus.
- Returns data_sram_rdata to the MEM stage and raises a stall request to the stall controller until the access completes.
- Sits between the CPU core and the system bus or data memory model.

---
 rtl/data_sram_bridge_pkg.sv | 19 +
 rtl/data_sram_bridge_timeout_ctr.sv | 29 ++
 rtl/data_sram_bridge.sv | 119 +++++++++++
 tb/tb_data_sram_bridge.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_bridge_pkg.sv
// Shared definitions for the data SRAM bridge: FSM encodings, the timeout
// read-data pattern and the width of the packed bus request.
package data_sram_bridge_pkg;

  typedef enum logic [1:0] {
    BR_IDLE = 2'd0,
    BR_REQ  = 2'd1,
    BR_WAIT = 2'd2,
    BR_DONE = 2'd3
  } br_state_t;

  localparam logic [31:0] BR_ERR_DATA = 32'hDEAD_BEEF;

  // Packed request layout: {we, wstrb, addr, wdata}
  function automatic int bus_req_w(input int addr_w, input int data_w);
    return 1 + data_w / 8 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/data_sram_bridge_timeout_ctr.sv
// Wait-cycle counter for the bridge: cleared when a request is accepted,
// advanced while waiting; done marks the last allowed wait cycle.
module data_sram_bridge_timeout_ctr #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_reg;

  assign done = (cnt_reg == W'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en && !done) begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

endmodule

// File: rtl/data_sram_bridge.sv
// Data SRAM port responder: latches one EX-stage access, runs it over a
// valid/ready bus and stalls the pipeline until it completes or times out.
module data_sram_bridge
  import data_sram_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(BR_ERR_DATA)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                data_sram_en,
  input  logic [DATA_W/8-1:0] data_sram_wen,
  input  logic [ADDR_W-1:0]   data_sram_addr,
  input  logic [DATA_W-1:0]   data_sram_wdata,
  output logic [DATA_W-1:0]   data_sram_rdata,
  output logic                stallreq_mem,
  output logic                bus_err,
  output logic                bus_req_valid,
  input  logic                bus_req_ready,
  output logic                bus_req_we,
  output logic [DATA_W/8-1:0] bus_req_wstrb,
  output logic [ADDR_W-1:0]   bus_req_addr,
  output logic [DATA_W-1:0]   bus_req_wdata,
  input  logic                bus_resp_valid,
  input  logic [DATA_W-1:0]   bus_resp_rdata
);

  localparam int REQ_W = bus_req_w(ADDR_W, DATA_W);

  br_state_t          state_reg, state_next;
  logic [REQ_W-1:0]   req_reg, req_next;
  logic [DATA_W-1:0]  rdata_reg;
  logic               bus_err_reg;
  logic               load_req, capture, timeout;
  logic               ctr_clr, ctr_en, ctr_done;

  assign req_next = {|data_sram_wen, data_sram_wen,
                     data_sram_addr & ~ADDR_W'(3), data_sram_wdata};

  assign {bus_req_we, bus_req_wstrb, bus_req_addr, bus_req_wdata} = req_reg;
  assign data_sram_rdata = rdata_reg;
  assign bus_err         = bus_err_reg;

  data_sram_bridge_timeout_ctr #(.LIMIT(TIMEOUT)) u_timeout_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (ctr_clr),
    .en   (ctr_en),
    .done (ctr_done)
  );

  always_comb begin
    state_next    = state_reg;
    stallreq_mem  = 1'b0;
    bus_req_valid = 1'b0;
    load_req      = 1'b0;
    capture       = 1'b0;
    timeout       = 1'b0;
    ctr_clr       = 1'b0;
    ctr_en        = 1'b0;
    case (state_reg)
      BR_IDLE: begin
        stallreq_mem = data_sram_en;
        if (data_sram_en) begin
          load_req   = 1'b1;
          state_next = BR_REQ;
        end
      end
      BR_REQ: begin
        stallreq_mem  = 1'b1;
        bus_req_valid = 1'b1;
        if (bus_req_ready) begin
          ctr_clr    = 1'b1;
          state_next = BR_WAIT;
        end
      end
      BR_WAIT: begin
        stallreq_mem = 1'b1;
        ctr_en       = 1'b1;
        // A response in the timeout cycle still counts as a normal completion.
        if (bus_resp_valid) begin
          capture    = 1'b1;
          state_next = BR_DONE;
        end else if (ctr_done) begin
          timeout    = 1'b1;
          state_next = BR_DONE;
        end
      end
      BR_DONE: begin
        state_next = BR_IDLE;
      end
      default: state_next = BR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= BR_IDLE;
      req_reg     <= '0;
      rdata_reg   <= '0;
      bus_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bus_err_reg <= timeout;
      if (load_req) begin
        req_reg <= req_next;
      end
      // Writes never disturb the last load value.
      if (capture && !bus_req_we) begin
        rdata_reg <= bus_resp_rdata;
      end else if (timeout && !bus_req_we) begin
        rdata_reg <= ERR_DATA;
      end
    end
  end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed bench for data_sram_bridge (TIMEOUT=8): zero-wait read, write with
// backpressure, timeout, collision, async reset and back-to-back reads.
module tb_data_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq_mem;
  logic        bus_err;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_req_we;
  logic [3:0]  bus_req_wstrb;
  logic [31:0] bus_req_addr;
  logic [31:0] bus_req_wdata;
  logic        bus_resp_valid;
  logic [31:0] bus_resp_rdata;

  int vectors = 0;
  int miscompares = 0;
  int stall_cnt;

  data_sram_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .stallreq_mem    (stallreq_mem),
    .bus_err         (bus_err),
    .bus_req_valid   (bus_req_valid),
    .bus_req_ready   (bus_req_ready),
    .bus_req_we      (bus_req_we),
    .bus_req_wstrb   (bus_req_wstrb),
    .bus_req_addr    (bus_req_addr),
    .bus_req_wdata   (bus_req_wdata),
    .bus_resp_valid  (bus_resp_valid),
    .bus_resp_rdata  (bus_resp_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a read from IDLE and leave the DUT in its first WAIT cycle.
  task automatic start_read(input logic [31:0] addr);
    data_sram_en   = 1'b1;
    data_sram_wen  = 4'b0000;
    data_sram_addr = addr;
    bus_req_ready  = 1'b1;
    tick();                 // REQ
    data_sram_en = 1'b0;
    tick();                 // WAIT
  endtask

  initial begin
    rst             = 1'b1;
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'b0000;
    data_sram_addr  = '0;
    data_sram_wdata = '0;
    bus_req_ready   = 1'b0;
    bus_resp_valid  = 1'b0;
    bus_resp_rdata  = '0;
    tick();
    check_vec("reset_valid", 32'(bus_req_valid), 32'd0);
    check_vec("reset_stall", 32'(stallreq_mem), 32'd0);
    check_vec("reset_err", 32'(bus_err), 32'd0);
    check_vec("reset_rdata", data_sram_rdata, 32'h0);
    rst = 1'b0;
    tick();

    // Read, zero-wait
    stall_cnt = 0;
    data_sram_en   = 1'b1;
    data_sram_wen  = 4'b0000;
    data_sram_addr = 32'h0000_1006;
    bus_req_ready  = 1'b1;
    #1;
    if (stallreq_mem) stall_cnt++;
    tick();
    data_sram_en = 1'b0;
    check_vec("rd_valid", 32'(bus_req_valid), 32'd1);
    check_vec("rd_addr", bus_req_addr, 32'h0000_1004);
    check_vec("rd_we", 32'(bus_req_we), 32'd0);
    if (stallreq_mem) stall_cnt++;
    tick();
    bus_resp_valid = 1'b1;
    bus_resp_rdata = 32'h1234_5678;
    if (stallreq_mem) stall_cnt++;
    tick();
    bus_resp_valid = 1'b0;
    if (stallreq_mem) stall_cnt++;
    check_vec("rd_stall_cycles", 32'(stall_cnt), 32'd3);
    check_vec("rd_done_stall", 32'(stallreq_mem), 32'd0);
    check_vec("rd_rdata", data_sram_rdata, 32'h1234_5678);
    tick();
    check_vec("rd_idle_stall", 32'(stallreq_mem), 32'd0);

    // Byte write with 4 cycles of backpressure; inputs scrambled during the stall
    data_sram_en    = 1'b1;
    data_sram_wen   = 4'b0010;
    data_sram_addr  = 32'h0000_2003;
    data_sram_wdata = 32'h0000_AB00;
    bus_req_ready   = 1'b0;
    tick();
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'b1111;
    data_sram_addr  = 32'hFFFF_FFFF;
    data_sram_wdata = 32'h1111_1111;
    for (int i = 0; i < 4; i++) begin
      check_vec($sformatf("wr_ctl[%0d]", i), {26'd0, bus_req_valid, bus_req_we, bus_req_wstrb}, {26'd0, 1'b1, 1'b1, 4'b0010});
      check_vec($sformatf("wr_addr[%0d]", i), bus_req_addr, 32'h0000_2000);
      check_vec($sformatf("wr_data[%0d]", i), bus_req_wdata, 32'h0000_AB00);
      tick();
    end
    bus_req_ready = 1'b1;
    check_vec("wr_ctl_hs", {26'd0, bus_req_valid, bus_req_we, bus_req_wstrb}, {26'd0, 1'b1, 1'b1, 4'b0010});
    tick();
    bus_req_ready = 1'b0;
    check_vec("wr_wait_valid", 32'(bus_req_valid), 32'd0);
    check_vec("wr_wait_stall", 32'(stallreq_mem), 32'd1);
    tick();
    bus_resp_valid = 1'b1;
    bus_resp_rdata = 32'h5555_5555;
    tick();
    bus_resp_valid = 1'b0;
    check_vec("wr_done_stall", 32'(stallreq_mem), 32'd0);
    check_vec("wr_rdata_kept", data_sram_rdata, 32'h1234_5678);
    check_vec("wr_err", 32'(bus_err), 32'd0);
    tick();

    // Timeout: 8 WAIT cycles with no response
    start_read(32'h0000_3000);
    for (int i = 0; i < 8; i++) begin
      check_vec($sformatf("to_wait_stall[%0d]", i), 32'(stallreq_mem), 32'd1);
      check_vec($sformatf("to_wait_err[%0d]", i), 32'(bus_err), 32'd0);
      tick();
    end
    check_vec("to_err", 32'(bus_err), 32'd1);
    check_vec("to_rdata", data_sram_rdata, 32'hDEAD_BEEF);
    check_vec("to_stall", 32'(stallreq_mem), 32'd0);
    tick();
    check_vec("to_err_pulse", 32'(bus_err), 32'd0);

    // Response arrives in the timeout cycle
    start_read(32'h0000_3004);
    for (int i = 0; i < 7; i++) tick();
    bus_resp_valid = 1'b1;
    bus_resp_rdata = 32'h0000_0001;
    tick();
    bus_resp_valid = 1'b0;
    check_vec("col_rdata", data_sram_rdata, 32'h0000_0001);
    check_vec("col_err", 32'(bus_err), 32'd0);
    check_vec("col_stall", 32'(stallreq_mem), 32'd0);
    tick();

    // Async reset mid-cycle in WAIT
    start_read(32'h0000_4000);
    tick();
    check_vec("ar_pre_stall", 32'(stallreq_mem), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_vec("ar_valid", 32'(bus_req_valid), 32'd0);
    check_vec("ar_stall", 32'(stallreq_mem), 32'd0);
    check_vec("ar_rdata", data_sram_rdata, 32'h0);
    tick();
    rst = 1'b0;
    bus_resp_valid = 1'b1;
    bus_resp_rdata = 32'h7777_7777;
    tick();
    tick();
    bus_resp_valid = 1'b0;
    check_vec("ar_late_resp_rdata", data_sram_rdata, 32'h0);
    check_vec("ar_late_resp_stall", 32'(stallreq_mem), 32'd0);

    // Stray response in IDLE, then back-to-back reads
    bus_resp_valid = 1'b1;
    bus_resp_rdata = 32'h0000_0BAD;
    tick();
    tick();
    bus_resp_valid = 1'b0;
    check_vec("stray_rdata", data_sram_rdata, 32'h0);
    check_vec("stray_stall", 32'(stallreq_mem), 32'd0);
    data_sram_en   = 1'b1;
    data_sram_wen  = 4'b0000;
    data_sram_addr = 32'h0000_0100;
    bus_req_ready  = 1'b1;
    tick();                         // REQ
    check_vec("b2b_a_addr", bus_req_addr, 32'h0000_0100);
    data_sram_addr = 32'h0000_0204;  // held for the next access
    tick();                         // WAIT
    bus_resp_valid = 1'b1;
    bus_resp_rdata = 32'hAAAA_1111;
    tick();                         // DONE, en still high but ignored
    bus_resp_valid = 1'b0;
    check_vec("b2b_a_rdata", data_sram_rdata, 32'hAAAA_1111);
    check_vec("b2b_done_stall", 32'(stallreq_mem), 32'd0);
    tick();                         // IDLE with en=1
    check_vec("b2b_idle_stall", 32'(stallreq_mem), 32'd1);
    tick();                         // REQ
    data_sram_en = 1'b0;
    check_vec("b2b_b_addr", bus_req_addr, 32'h0000_0204);
    tick();                         // WAIT
    bus_resp_valid = 1'b1;
    bus_resp_rdata = 32'hBBBB_2222;
    tick();                         // DONE
    bus_resp_valid = 1'b0;
    check_vec("b2b_b_rdata", data_sram_rdata, 32'hBBBB_2222);
    tick();
    check_vec("b2b_end_stall", 32'(stallreq_mem), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
